// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS main control FSM.
//   - 4-bit state encoding (also exported on the debug state port)
//   - opcode constants for the supported instruction classes
//   - alu_op, alu_src_b and pc_src encodings as seen by the datapath
//   - ctl_t: the full control word produced by mc_out_decode
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_JEX     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BNE   = 6'h05;

    // Must match the encodings expected by the ALU control decoder.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctl_t;

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: combinational map from the FSM state to the datapath
// control word. Moore decode, with pc_en/ir_write qualified by mem_ready
// (fetch) or zero XOR branch_ne (branch execute).
//   state     : current FSM state
//   zero      : ALU zero flag
//   mem_ready : memory finishes the current access this cycle
//   branch_ne : registered "branch on not-equal" flag (0 when BNE is disabled)
//   ctl       : control word; any field not set for a state is 0
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       branch_ne,
    output ctl_t       ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.iord      = 1'b0;
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_src    = PC_ALU;
                // PC+4 and IR load commit only when the fetch completes.
                ctl.ir_write  = mem_ready;
                ctl.pc_en     = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm<<2) into ALUOut.
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctl.reg_dst    = 1'b0;
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REGB;
                ctl.alu_op    = ALU_FUNCT;
            end
            S_RTYPEWB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            S_BEQEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REGB;
                ctl.alu_op    = ALU_SUB;
                ctl.pc_src    = PC_ALUOUT;
                // BEQ takes on zero, BNE on not-zero.
                ctl.pc_en     = zero ^ branch_ne;
            end
            S_JEX: begin
                ctl.pc_src = PC_JUMP;
                ctl.pc_en  = 1'b1;
            end
            S_ADDIWB: begin
                ctl.reg_dst   = 1'b0;
                ctl.reg_write = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctl.sv
// multicycle_ctl: main control FSM of the multicycle MIPS datapath.
// Holds the state register and next-state logic; output decode lives in
// mc_out_decode. Optional macro MC_BNE_EN adds BNE (opcode 6'h05) via the
// branch execute state; without it 6'h05 is treated as illegal.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   opcode              : instr[31:26], sampled in DECODE and MEMADR only
//   zero                : ALU zero flag
//   mem_ready           : memory completes the current access this cycle
//   pc_en, iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, alu_op, pc_src : datapath controls
//   illegal_op          : one-cycle pulse in DECODE on an unknown opcode
//   state               : current state code (debug)
module multicycle_ctl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    logic   illegal;
    logic   branch_ne_q;
    ctl_t   ctl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

`ifdef MC_BNE_EN
    // Remembers that the instruction in flight is BNE so the shared branch
    // execute state inverts the zero test.
    always_ff @(posedge clk) begin
        if (reset)                    branch_ne_q <= 1'b0;
        else if (state_q == S_DECODE) branch_ne_q <= (opcode == OP_BNE);
        else if (state_q == S_FETCH)  branch_ne_q <= 1'b0;
    end
`else
    assign branch_ne_q = 1'b0;
`endif

    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BEQEX;
`endif
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .zero      (zero),
        .mem_ready (mem_ready),
        .branch_ne (branch_ne_q),
        .ctl       (ctl)
    );

    // Write-type enables are suppressed during reset so an aborted
    // instruction cannot commit anything on the reset edge.
    assign pc_en      = ctl.pc_en     & ~reset;
    assign ir_write   = ctl.ir_write  & ~reset;
    assign mem_write  = ctl.mem_write & ~reset;
    assign reg_write  = ctl.reg_write & ~reset;
    assign illegal_op = illegal       & ~reset;

    assign iord       = ctl.iord;
    assign reg_dst    = ctl.reg_dst;
    assign mem_to_reg = ctl.mem_to_reg;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_op     = ctl.alu_op;
    assign pc_src     = ctl.pc_src;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctl.sv
// Testbench for multicycle_ctl: instruction-level reference model (state
// path per opcode, stall rule, per-state control table) with randomized
// opcodes, zero flag and memory-ready stalls, plus directed scenarios.
module tb_multicycle_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, ir_write, mem_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    int obs_mw, obs_ill, obs_rw, obs_pc8;
    int lat;
    int path[$];

    always #5 clk = ~clk;

    multicycle_ctl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .state      (state)
    );

    wire [14:0] obs = {pc_en, iord, ir_write, mem_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

    function automatic bit bne_en();
`ifdef MC_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        case (op)
            6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08: return 1'b1;
            6'h05: return bne_en();
            default: return 1'b0;
        endcase
    endfunction

    // Sequence of states one instruction visits, from its fetch onward.
    function automatic void build_path(logic [5:0] op);
        path.delete();
        case (op)
            6'h23: path = '{0, 1, 2, 3, 4};
            6'h2B: path = '{0, 1, 2, 5};
            6'h00: path = '{0, 1, 6, 7};
            6'h04: path = '{0, 1, 8};
            6'h02: path = '{0, 1, 9};
            6'h08: path = '{0, 1, 10, 11};
            6'h05: if (bne_en()) path = '{0, 1, 8}; else path = '{0, 1};
            default: path = '{0, 1};
        endcase
    endfunction

    // Control-word table: {pc_en,iord,ir_write,mem_write,reg_dst,mem_to_reg,
    // reg_write,alu_src_a,alu_src_b,alu_op,pc_src,illegal_op}
    function automatic logic [14:0] exp_word(int st, bit mr, bit z, logic [5:0] op, bit bne);
        logic pe, io, irw, mw, rd, m2r, rw, sa, ill;
        logic [1:0] sb, ao, ps;
        {pe, io, irw, mw, rd, m2r, rw, sa, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            0:  begin sb = 2'b01; irw = mr; pe = mr; end
            1:  begin sb = 2'b11; ill = !is_legal(op); end
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  io = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; ao = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = z ^ bne; end
            9:  begin ps = 2'b10; pe = 1'b1; end
            10: begin sa = 1'b1; sb = 2'b10; end
            11: rw = 1'b1;
            default: ;
        endcase
        return {pe, io, irw, mw, rd, m2r, rw, sa, sb, ao, ps, ill};
    endfunction

    // Runs one instruction from FETCH, checking every cycle against the model.
    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input bit z, input int stall_st,
                             input int stall_n, input bit rand_mr, output int cycles);
        int idx = 0;
        int left = stall_n;
        int exp_st;
        bit mr, bne;
        bne = bne_en() && (op == 6'h05);
        build_path(op);
        cycles = 0; obs_mw = 0; obs_ill = 0; obs_rw = 0; obs_pc8 = 0;
        while (idx < path.size()) begin
            if (cycles >= 64) begin
                n_checks++;
                $display("FAIL timeout op=%h: stuck in state %0d, wanted %0d", op, state, path[idx]);
                return;
            end
            exp_st = path[idx];
            if (rand_mr) mr = ($urandom_range(0, 3) != 0);
            else if (exp_st == stall_st && left > 0) begin mr = 1'b0; left--; end
            else mr = 1'b1;
            mem_ready = mr;
            zero      = (exp_st == 8) ? z : 1'($urandom_range(0, 1));
            opcode    = (exp_st == 1 || exp_st == 2) ? op : 6'($urandom);
            #1;
            n_checks++;
            if (state !== 4'(exp_st))
                $display("FAIL state op=%h cyc=%0d: got %0d want %0d", op, cycles, state, exp_st);
            else n_pass++;
            n_checks++;
            if (obs !== exp_word(exp_st, mr, zero, opcode, bne))
                $display("FAIL ctl op=%h st=%0d: got %b want %b", op, exp_st, obs,
                         exp_word(exp_st, mr, zero, opcode, bne));
            else n_pass++;
            obs_mw  += int'(mem_write);
            obs_ill += int'(illegal_op);
            obs_rw  += int'(reg_write);
            if (state == 4'd8) obs_pc8 += int'(pc_en);
            if (!((exp_st == 0 || exp_st == 3 || exp_st == 5) && !mr)) idx++;
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state);
        else n_pass++;
        n_checks++;
        if ({pc_en, ir_write, mem_write, reg_write, illegal_op} !== 5'b0)
            $display("FAIL reset_enables: got %b want 00000",
                     {pc_en, ir_write, mem_write, reg_write, illegal_op});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL reset_state2: got %0d want 0", state);
        else n_pass++;
        reset = 1'b0; #1;
        n_checks++;
        if ({ir_write, pc_en, alu_src_b} !== 4'b1101)
            $display("FAIL release_fetch: got %b want 1101", {ir_write, pc_en, alu_src_b});
        else n_pass++;
        mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_instr(6'h23, 1'b0, -1, 0, 1'b0, lat);
        n_checks++;
        if (lat !== 5) $display("FAIL lw_latency: got %0d want 5", lat); else n_pass++;
        n_checks++;
        if (obs_rw !== 1) $display("FAIL lw_regwrite_count: got %0d want 1", obs_rw); else n_pass++;
    endtask

    task automatic test_sw_stall();
        run_instr(6'h2B, 1'b0, 5, 3, 1'b0, lat);
        n_checks++;
        if (obs_mw !== 4) $display("FAIL sw_memwrite_cycles: got %0d want 4", obs_mw); else n_pass++;
        n_checks++;
        if (lat !== 7) $display("FAIL sw_latency: got %0d want 7", lat); else n_pass++;
    endtask

    task automatic test_beq();
        run_instr(6'h04, 1'b1, -1, 0, 1'b0, lat);
        n_checks++;
        if (obs_pc8 !== 1) $display("FAIL beq_taken: got %0d want 1", obs_pc8); else n_pass++;
        run_instr(6'h04, 1'b0, -1, 0, 1'b0, lat);
        n_checks++;
        if (obs_pc8 !== 0) $display("FAIL beq_not_taken: got %0d want 0", obs_pc8); else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL beq_latency: got %0d want 3", lat); else n_pass++;
    endtask

    task automatic test_rtype_illegal();
        run_instr(6'h00, 1'b0, -1, 0, 1'b0, lat);
        n_checks++;
        if (lat !== 4) $display("FAIL rtype_latency: got %0d want 4", lat); else n_pass++;
        run_instr(6'h3F, 1'b0, -1, 0, 1'b0, lat);
        n_checks++;
        if (obs_ill !== 1) $display("FAIL illegal_pulses: got %0d want 1", obs_ill); else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL illegal_latency: got %0d want 2", lat); else n_pass++;
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b1; opcode = 6'h3F;
        @(posedge clk); #1;
        opcode = 6'h23;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0; #1;
        n_checks++;
        if (state !== 4'd3) $display("FAIL mid_reach_memrd: got %0d want 3", state); else n_pass++;
        reset = 1'b1; mem_ready = 1'b1; #1;
        n_checks++;
        if ({pc_en, ir_write, mem_write, reg_write} !== 4'b0)
            $display("FAIL mid_reset_enables: got %b want 0000",
                     {pc_en, ir_write, mem_write, reg_write});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL mid_reset_state: got %0d want 0", state); else n_pass++;
        reset = 1'b0; mem_ready = 1'b0; #1;
        n_checks++;
        if (reg_write !== 1'b0) $display("FAIL mid_no_regwrite: got %b want 0", reg_write); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL mid_stay_fetch: got %0d want 0", state); else n_pass++;
    endtask

    task automatic test_bne();
        run_instr(6'h05, 1'b0, -1, 0, 1'b0, lat);
        if (bne_en()) begin
            n_checks++;
            if (obs_pc8 !== 1) $display("FAIL bne_taken: got %0d want 1", obs_pc8); else n_pass++;
            run_instr(6'h05, 1'b1, -1, 0, 1'b0, lat);
            n_checks++;
            if (obs_pc8 !== 0) $display("FAIL bne_not_taken: got %0d want 0", obs_pc8); else n_pass++;
        end else begin
            n_checks++;
            if (obs_ill !== 1) $display("FAIL bne_illegal: got %0d want 1", obs_ill); else n_pass++;
        end
    endtask

    task automatic test_latency();
        logic [5:0] ops [6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
        int         want[6] = '{5, 4, 4, 4, 3, 3};
        for (int i = 0; i < 6; i++) begin
            run_instr(ops[i], 1'($urandom_range(0, 1)), -1, 0, 1'b0, lat);
            n_checks++;
            if (lat !== want[i])
                $display("FAIL latency op=%h: got %0d want %0d", ops[i], lat, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [5:0] pool [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h05};
        logic [5:0] op;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = pool[$urandom_range(0, 6)];
            run_instr(op, 1'($urandom_range(0, 1)), -1, 0, 1'b1, lat);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rtype_illegal();
        test_reset_mid();
        test_bne();
        test_latency();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
